// File: rtl/riscv_pkg.sv
// Shared register-file constants and the write-back queue entry layout.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wq_match.sv
// Flags whether one decode-stage source register has a write still sitting in the queue.
module rf_wq_match
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW
) (
  input  logic [AW-1:0]            addr,
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] rds,
  output logic                     busy
);

  // x0 is hardwired to zero, so it can never be a RAW hazard.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (rds[i] == addr)) begin
        busy = 1'b1;
      end
    end
    if (addr == '0) begin
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// In-order write queue in front of the register file write port; drains one entry per cycle
// and reports per-source pending-write status for decode stalls.
module rf_write_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int AW    = riscv_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we3,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] wd3,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic            busy1,
  output logic            busy2,
  output logic            full,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t                entries [DEPTH];
  logic [DEPTH-1:0]         valid;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free;
  logic                     lsu_push;
  logic                     alu_push;
  logic                     pop;
  logic [1:0]               push_cnt;
  logic [PW-1:0]            alu_slot;
  logic [DEPTH-1:0][AW-1:0] rds;

  // Readiness looks only at the start-of-cycle count; a simultaneous pop frees nothing.
  assign free      = DEPTH_C - count;
  assign lsu_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~lsu_valid);

  // Writes to x0 complete the handshake but never occupy a slot.
  assign lsu_push = lsu_valid & lsu_ready & (lsu_rd != '0);
  assign alu_push = alu_valid & alu_ready & (alu_rd != '0);
  assign push_cnt = {1'b0, lsu_push} + {1'b0, alu_push};
  assign alu_slot = tail + PW'(lsu_push);
  assign pop      = (count != '0);

  assign we3   = pop;
  assign a3    = entries[head].rd;
  assign wd3   = entries[head].data;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (lsu_push) begin
        valid[tail] <= 1'b1;
      end
      if (alu_push) begin
        valid[alu_slot] <= 1'b1;
      end
      tail  <= tail + PW'(push_cnt);
      count <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  // The load is older in program order, so it takes the tail slot when both are accepted.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      entries[tail].rd   <= lsu_rd;
      entries[tail].data <= lsu_data;
    end
    if (alu_push) begin
      entries[alu_slot].rd   <= alu_rd;
      entries[alu_slot].data <= alu_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rds[i] = entries[i].rd;
    end
  end

  rf_wq_match #(.DEPTH(DEPTH), .AW(AW)) u_match1 (
    .addr  (a1),
    .valid (valid),
    .rds   (rds),
    .busy  (busy1)
  );

  rf_wq_match #(.DEPTH(DEPTH), .AW(AW)) u_match2 (
    .addr  (a2),
    .valid (valid),
    .rds   (rds),
    .busy  (busy2)
  );

endmodule

// File: tb/tb_rf_write_queue.sv
// Checks rf_write_queue against a queue-based model of the write buffer and a shadow regfile.
module tb_rf_write_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd, a1, a2, a3;
  logic [31:0] alu_data, lsu_data, wd3;
  logic        alu_ready, lsu_ready, we3, busy1, busy2, full, empty;

  int          checks = 0;
  int          errors = 0;
  ent_t        mq[$];
  logic [4:0]  seq_log[$];
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf [32];

  rf_write_queue #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .a1        (a1),
    .a2        (a2),
    .busy1     (busy1),
    .busy2     (busy2),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check the combinational view, then advance the model at the edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] s1, input logic [4:0] s2);
    int          fr;
    logic        er_a, er_l, swe;
    logic [4:0]  sa;
    logic [31:0] sd;
    ent_t        e;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    a1 = s1; a2 = s2;
    #1;
    fr   = DEPTH - mq.size();
    er_l = (fr >= 1);
    er_a = (fr >= 2) || ((fr == 1) && !lv);
    chk("lsu_ready", lsu_ready, er_l);
    chk("alu_ready", alu_ready, er_a);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("we3", we3, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("a3", a3, mq[0].rd);
      chk("wd3", wd3, mq[0].data);
    end
    chk("busy1", busy1, model_busy(s1));
    chk("busy2", busy2, model_busy(s2));
    swe = we3; sa = a3; sd = wd3;
    @(posedge clk);
    if (swe) begin
      dut_rf[sa] = sd;
      seq_log.push_back(sa);
    end
    if (mq.size() != 0) begin
      model_rf[mq[0].rd] = mq[0].data;
      void'(mq.pop_front());
    end
    if (lv && er_l && (lrd != 5'd0)) begin
      e.rd = lrd; e.data = ld; mq.push_back(e);
    end
    if (av && er_a && (ard != 5'd0)) begin
      e.rd = ard; e.data = ad; mq.push_back(e);
    end
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) idle(5'd0, 5'd0);
  endtask

  // Asynchronous reset landing in the middle of a cycle; queued writes must vanish.
  task automatic pulse_reset(input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    alu_valid = 1'b0; lsu_valid = 1'b0; a1 = s1; a2 = s2;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    chk("rst_we3", we3, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    a1 = 5'd5; a2 = 5'd7;
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = '0;
      dut_rf[r]   = '0;
    end
    #1;
    chk("init_we3", we3, 1'b0);
    chk("init_empty", empty, 1'b1);
    chk("init_full", full, 1'b0);
    chk("init_busy1", busy1, 1'b0);
    chk("init_busy2", busy2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset with three queued writes");
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 32'h11, 5'd0, 5'd0);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    pulse_reset(5'd3, 5'd4);
    idle(5'd3, 5'd4);
    idle(5'd2, 5'd0);
    chk("t1_rf1", dut_rf[1], 32'h11);
    chk("t1_rf2", dut_rf[2], 32'h0);
    chk("t1_rf3", dut_rf[3], 32'h0);
    chk("t1_rf4", dut_rf[4], 32'h0);

    $display("[TB] single ALU write latency");
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    #1;
    chk("t2_we3", we3, 1'b1);
    chk("t2_a3", a3, 5'd5);
    chk("t2_wd3", wd3, 32'h1234);
    chk("t2_busy1", busy1, 1'b1);
    idle(5'd5, 5'd0);
    #1;
    chk("t2_empty", empty, 1'b1);
    chk("t2_busy1_clr", busy1, 1'b0);

    $display("[TB] same-cycle LSU and ALU to one register");
    step(1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd7, 32'hAAAA, 5'd7, 5'd0);
    drain();
    chk("t3_rf7", dut_rf[7], 32'hBBBB);

    $display("[TB] fill with drain active");
    step(1'b1, 5'd9, 32'h9, 1'b1, 5'd8, 32'h8, 5'd8, 5'd9);
    step(1'b1, 5'd11, 32'hB, 1'b1, 5'd10, 32'hA, 5'd10, 5'd11);
    #1;
    chk("t4_lsu_ready", lsu_ready, 1'b1);
    chk("t4_alu_ready", alu_ready, 1'b0);
    step(1'b1, 5'd13, 32'hD, 1'b1, 5'd12, 32'hC, 5'd12, 5'd13);
    drain();

    $display("[TB] write to x0");
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    chk("t5_empty", empty, 1'b1);
    chk("t5_we3", we3, 1'b0);
    chk("t5_busy1", busy1, 1'b0);

    $display("[TB] pointer wrap stream");
    seq_log.delete();
    for (int i = 1; i <= 10; i++) step(1'b1, 5'(i), 32'(i * 256), 1'b0, 5'd0, 32'd0, 5'(i), 5'd0);
    drain();
    chk("t6_count", seq_log.size(), 10);
    for (int i = 0; i < seq_log.size() && i < 10; i++) chk("t6_order", seq_log[i], 5'(i + 1));

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pulse_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    drain();
    for (int r = 0; r < 32; r++) chk("final_rf", dut_rf[r], model_rf[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
